// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - Multi-cycle multiply/divide unit with architectural HI/LO
// Optional feature macro: MDU_MADD_EN enables madd (MDOp 7) and maddu (MDOp 8).
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   A, B        operands rs/rt; A is also the mthi/mtlo write value
//   MDOp        operation code (1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7/8 madd/maddu)
//   start       qualifies multi-cycle operations
//   busy        high while an operation is in flight
//   HI, LO      architectural result registers
module mdu_seq #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDOp,
   input  logic        start,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MADD  = 4'd7;
   localparam logic [3:0] OP_MADDU = 4'd8;

   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES - 1);

   state_t      state;
   logic [3:0]  cnt;
   logic [3:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic        accept;

   always_comb begin
      accept = start && (MDOp == OP_MULT || MDOp == OP_MULTU ||
                         MDOp == OP_DIV  || MDOp == OP_DIVU);
`ifdef MDU_MADD_EN
      if (start && (MDOp == OP_MADD || MDOp == OP_MADDU))
         accept = 1'b1;
`endif
   end

   // Datapath works on the latched operands and is consumed at the commit edge.
   logic [63:0] prod_s;
   logic [63:0] prod_u;
   assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   // A zero divisor never commits; substituting 1 keeps the dividers defined.
   logic [31:0] b_div_u;
   logic [31:0] q_u;
   logic [31:0] r_u;
   assign b_div_u = (b_q == 32'd0) ? 32'd1 : b_q;
   assign q_u     = a_q / b_div_u;
   assign r_u     = a_q % b_div_u;

   // Signed divide on magnitudes. 0x80000000 has magnitude 2^31 in 32 bits,
   // so 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0.
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_m;
   logic [31:0] r_m;
   logic [31:0] q_s;
   logic [31:0] r_s;
   assign a_mag = a_q[31] ? -a_q : a_q;
   assign b_mag = (b_q == 32'd0) ? 32'd1 : (b_q[31] ? -b_q : b_q);
   assign q_m   = a_mag / b_mag;
   assign r_m   = a_mag % b_mag;
   assign q_s   = (a_q[31] ^ b_q[31]) ? -q_m : q_m;
   assign r_s   = a_q[31] ? -r_m : r_m;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= 4'd0;
         op_q  <= 4'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         HI    <= 32'd0;
         LO    <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= RUN;
                  busy  <= 1'b1;
                  op_q  <= MDOp;
                  a_q   <= A;
                  b_q   <= B;
                  cnt   <= (MDOp == OP_DIV || MDOp == OP_DIVU) ? DIV_LAT : MULT_LAT;
               end else if (MDOp == OP_MTHI) begin
                  HI <= A;
               end else if (MDOp == OP_MTLO) begin
                  LO <= A;
               end
            end
            RUN: begin
               if (cnt == 4'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  case (op_q)
                     OP_MULT:  {HI, LO} <= prod_s;
                     OP_MULTU: {HI, LO} <= prod_u;
                     OP_DIV: begin
                        if (b_q != 32'd0) begin
                           LO <= q_s;
                           HI <= r_s;
                        end
                     end
                     OP_DIVU: begin
                        if (b_q != 32'd0) begin
                           LO <= q_u;
                           HI <= r_u;
                        end
                     end
`ifdef MDU_MADD_EN
                     OP_MADD:  {HI, LO} <= {HI, LO} + prod_s;
                     OP_MADDU: {HI, LO} <= {HI, LO} + prod_u;
`endif
                     default: ;
                  endcase
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// tb/tb_mdu_seq.sv - Self-checking testbench for mdu_seq
module tb_mdu_seq;

   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  MDOp;
   logic        start;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   mdu_seq #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (A),
      .B     (B),
      .MDOp  (MDOp),
      .start (start),
      .busy  (busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural reference: result of one operation from the ISA rules.
   function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, b, hi, lo,
                                  output logic [31:0] nh, nl, output int lat);
      longint          sa64;
      longint          sb64;
      longint          ps;
      longint unsigned ua;
      longint unsigned ub;
      longint unsigned pu;
      int              sa;
      int              sb;
      sa64 = $signed(a);
      sb64 = $signed(b);
      ps   = sa64 * sb64;
      ua   = a;
      ub   = b;
      pu   = ua * ub;
      nh   = hi;
      nl   = lo;
      lat  = MULT_CYCLES;
      case (op)
         4'd1: {nh, nl} = ps;
         4'd2: {nh, nl} = pu;
         4'd3: begin
            lat = DIV_CYCLES;
            if (b != 0) begin
               if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                  nl = 32'h8000_0000;
                  nh = 32'h0;
               end else begin
                  sa = a;
                  sb = b;
                  nl = sa / sb;
                  nh = sa % sb;
               end
            end
         end
         4'd4: begin
            lat = DIV_CYCLES;
            if (b != 0) begin
               nl = a / b;
               nh = a % b;
            end
         end
         4'd7: {nh, nl} = {hi, lo} + ps;
         4'd8: {nh, nl} = {hi, lo} + pu;
         default: ;
      endcase
   endfunction

   // Issue one multi-cycle op; disturb the inputs while busy (mthi, a
   // competing divu, then random traffic), all of which must be ignored.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, b, input string nm);
      logic [31:0] eh;
      logic [31:0] el;
      int          lat;
      ref_op(op, a, b, m_hi, m_lo, eh, el, lat);
      MDOp = op; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_first: got %b want 1", nm, busy);
      end
      for (int i = 1; i <= lat; i++) begin
         case (i)
            1: begin MDOp = 4'd5; A = 32'h1234; B = 32'h0; start = 1'b0; end
            2: begin MDOp = 4'd4; A = 32'd9; B = 32'd3; start = 1'b1; end
            default: begin
               MDOp = 4'($urandom_range(0, 15)); A = $urandom; B = $urandom;
               start = 1'($urandom);
            end
         endcase
         @(posedge clk); #1;
         if (i < lat) begin
            n_checks++;
            if (busy !== 1'b1 || HI !== m_hi || LO !== m_lo) begin
               n_fail++;
               $display("FAIL %s during_busy cycle %0d: got busy=%b HI=%h LO=%h want busy=1 HI=%h LO=%h",
                        nm, i, busy, HI, LO, m_hi, m_lo);
            end
         end
      end
      MDOp = 4'd0; start = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || HI !== eh || LO !== el) begin
         n_fail++;
         $display("FAIL %s commit: got busy=%b HI=%h LO=%h want busy=0 HI=%h LO=%h",
                  nm, busy, HI, LO, eh, el);
      end
      m_hi = eh;
      m_lo = el;
   endtask

   task automatic run_move(input logic hi_sel, input logic [31:0] val, input logic st, input string nm);
      MDOp = hi_sel ? 4'd5 : 4'd6; A = val; B = $urandom; start = st;
      @(posedge clk); #1;
      MDOp = 4'd0; start = 1'b0;
      if (hi_sel) m_hi = val; else m_lo = val;
      n_checks++;
      if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
         n_fail++;
         $display("FAIL %s: got busy=%b HI=%h LO=%h want busy=0 HI=%h LO=%h",
                  nm, busy, HI, LO, m_hi, m_lo);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; MDOp = 4'd5; A = 32'hDEAD_BEEF; B = 32'h1; start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0; MDOp = 4'd0; start = 1'b0;
      m_hi = 32'h0; m_lo = 32'h0;
      n_checks++;
      if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
      end
   endtask

   task automatic test_directed();
      run_op(4'd1, 32'hFFFF_FFFF, 32'h2, "mult_m1x2");
      run_op(4'd2, 32'hFFFF_FFFF, 32'h2, "multu_ffx2");
      run_op(4'd3, 32'hFFFF_FFF9, 32'h2, "div_m7d2");
      run_op(4'd4, 32'd7, 32'd2, "divu_7d2");
      run_op(4'd4, 32'd5, 32'd0, "divu_by_zero");
      run_op(4'd3, 32'h1234, 32'd0, "div_by_zero");
      run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      run_op(4'd3, 32'd7, 32'hFFFF_FFFE, "div_7dm2");
      run_op(4'd1, 32'd3, 32'd4, "mult_3x4_ignore");
      n_checks++;
      if (HI !== 32'h0 || LO !== 32'd12) begin
         n_fail++;
         $display("FAIL ignore_busy_final: got HI=%h LO=%h want HI=0 LO=c", HI, LO);
      end
   endtask

   task automatic test_move();
      run_move(1'b0, 32'hABCD, 1'b0, "mtlo_abcd");
      run_move(1'b1, 32'h5A5A_0001, 1'b1, "mthi_with_start");
      run_move(1'b0, $urandom, 1'b1, "mtlo_random");
   endtask

   task automatic test_noop();
      logic [3:0] ops[$];
      ops = '{4'd0, 4'd9, 4'd12, 4'd15};
`ifndef MDU_MADD_EN
      ops.push_back(4'd7);
      ops.push_back(4'd8);
`endif
      foreach (ops[i]) begin
         MDOp = ops[i]; A = $urandom; B = $urandom; start = 1'b1;
         @(posedge clk); #1;
         MDOp = 4'd0; start = 1'b0;
         n_checks++;
         if (busy !== 1'b0 || HI !== m_hi || LO !== m_lo) begin
            n_fail++;
            $display("FAIL noop op=%0d: got busy=%b HI=%h LO=%h want busy=0 HI=%h LO=%h",
                     ops[i], busy, HI, LO, m_hi, m_lo);
         end
      end
   endtask

   task automatic test_reset_mid();
      run_move(1'b1, 32'h66, 1'b0, "pre_mthi");
      run_move(1'b0, 32'h55, 1'b0, "pre_mtlo");
      MDOp = 4'd3; A = 32'd100; B = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      MDOp = 4'd0; start = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         n_checks++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid busy_before: got %b want 1", busy);
         end
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_hi = 32'h0; m_lo = 32'h0;
      n_checks++;
      if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid after_reset: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
      end
      repeat (DIV_CYCLES) @(posedge clk);
      #1;
      n_checks++;
      if (busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_mid no_commit: got busy=%b HI=%h LO=%h want 0/0/0", busy, HI, LO);
      end
   endtask

`ifdef MDU_MADD_EN
   task automatic test_madd();
      run_move(1'b0, 32'd5, 1'b0, "madd_pre_mtlo");
      run_op(4'd7, 32'hFFFF_FFFF, 32'd1, "madd_m1x1");
      n_checks++;
      if (HI !== 32'h0 || LO !== 32'd4) begin
         n_fail++;
         $display("FAIL madd_final: got HI=%h LO=%h want HI=0 LO=4", HI, LO);
      end
      run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "maddu_big");
      run_op(4'd7, 32'h8000_0000, 32'h8000_0000, "madd_minmin");
   endtask
`endif

   task automatic test_random();
      logic [3:0]  ops[$];
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      ops = '{4'd1, 4'd2, 4'd3, 4'd4};
`ifdef MDU_MADD_EN
      ops.push_back(4'd7);
      ops.push_back(4'd8);
`endif
      for (int n = 0; n < 30; n++) begin
         op = ops[$urandom_range(0, ops.size() - 1)];
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 15))
            0:       b = 32'd0;
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       b = 32'($urandom_range(1, 9));
            3:       a = -32'($urandom_range(0, 100));
            default: ;
         endcase
         run_op(op, a, b, "random_op");
      end
   endtask

   initial begin
      reset = 1'b0; A = 32'h0; B = 32'h0; MDOp = 4'd0; start = 1'b0;
      m_hi = 32'h0; m_lo = 32'h0;
      @(posedge clk); #1;
      test_reset();
      test_directed();
      test_move();
      test_noop();
      test_reset_mid();
`ifdef MDU_MADD_EN
      test_madd();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
